// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a valid/ready stream through a two-entry buffer.
// Define FIFO_RD_STATS_EN to add the 16-bit xfer_count accepted-word counter.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_n;
  logic inflight, pop;
  logic [WIDTH-1:0] head, tail, head_n, tail_n;
  assign m_valid = state != EMPTY;
  assign m_data  = head;
  assign pop     = m_valid & m_ready;
  // State encoding doubles as occupancy; a read is issued only if it cannot overfill the buffer.
  assign fifo_ren = !rst && !fifo_empty && (({1'b0, state} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    case (state)
      EMPTY: if (inflight) begin
        state_n = ONE;
        head_n  = fifo_rdata;
      end
      ONE: if (inflight && pop) head_n = fifo_rdata;
        else if (inflight) begin
          state_n = TWO;
          tail_n  = fifo_rdata;
        end
        else if (pop) state_n = EMPTY;
      default: if (pop) begin
        state_n = inflight ? TWO : ONE;
        head_n  = tail;
        tail_n  = fifo_rdata;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      assert (!(state == TWO && inflight && !pop));
      state    <= state_n;
      inflight <= fifo_ren;
      head     <= head_n;
      tail     <= tail_n;
    end
  end
`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of fifo_stream_reader against a behavioural FIFO.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst, fifo_empty, fifo_ren, m_valid, m_ready, flush;
  logic [7:0] fifo_rdata, m_data;
  logic [7:0] mem [0:255];
  logic [7:0] got [0:1023];
  int unsigned wr_ptr = 0, rd_ptr = 0;
  int ngot = 0, ren_bad = 0, checks = 0, errors = 0;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] xfer_count;
`endif

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIFO_RD_STATS_EN
    , .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty = rd_ptr == wr_ptr;
  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_ren) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (ngot < 1024) got[ngot] = m_data;
        ngot++;
      end
      if (fifo_ren && fifo_empty) ren_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  initial begin
    int rens, n, base;
    rst = 1'b1;
    m_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_ren", fifo_ren, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_ren", fifo_ren, 1);
    @(negedge clk);
    #1;
    check("cycle1_valid", m_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("stream_valid", m_valid, 1);
      check("stream_data", m_data, 32'h11 + i);
    end
    @(negedge clk);
    #1;
    check("stream_end_valid", m_valid, 0);

    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    rens = 0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      rens += int'(fifo_ren);
    end
    check("bp_ren_pulses", rens, 2);
    check("bp_hold_valid", m_valid, 1);
    check("bp_hold_data", m_data, 32'h11);
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      check("resume_valid", m_valid, 1);
      check("resume_data", m_data, 32'h11 + i);
    end

    @(negedge clk);
    base = ngot;
    for (int i = 0; i < 30; i++) push(pat(i));
    n = 0;
    while ((ngot - base) < 30 && n < 300) begin
      m_ready = n[0] == 1'b0;
      @(negedge clk);
      n++;
    end
    m_ready = 1'b1;
    check("alt_count", ngot - base, 30);
    for (int i = 0; i < 30; i++) check("alt_word", {24'b0, got[base + i]}, {24'b0, pat(i)});
    check("alt_ren_while_empty", ren_bad, 0);

    repeat (3) @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_valid_before_rst", m_valid, 1);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    base = ngot;
    push(8'hA5);
    push(8'h5A);
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_count", ngot - base, 2);
    check("mid_word0", {24'b0, got[base]}, 32'hA5);
    check("mid_word1", {24'b0, got[base + 1]}, 32'h5A);

`ifdef FIFO_RD_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stats_reset", xfer_count, 0);
    wr_ptr += 65537;
    n = 0;
    while ((rd_ptr != wr_ptr || m_valid) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("stats_timeout", n < 70000, 1);
    #1;
    check("stats_wrap", xfer_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
